// File: rtl/seq_pkg.sv
// Shared definitions for the sequential Y86-64 stage sequencer: instruction
// codes, status codes and the stage FSM state type.
package seq_pkg;

    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        PCUPD     = 3'd6,
        STOP      = 3'd7
    } seq_state_e;

    // Codes above popq are not part of the Y86-64 instruction set.
    function automatic logic isInvalidIcode(input logic [3:0] code);
        return code > IPOPQ;
    endfunction

endpackage

// File: rtl/seq_pc_select.sv
// Combinational next-PC selection from the captured instruction results.
module seq_pc_select
    import seq_pkg::*;
(
    input  logic [3:0]  i_icode,
    input  logic        i_cnd,
    input  logic [63:0] i_valC,
    input  logic [63:0] i_valP,
    input  logic [63:0] i_valM,
    output logic [63:0] o_newPc
);

    always_comb begin
        o_newPc = i_valP;
        case (i_icode)
            ICALL:   o_newPc = i_valC;
            IJXX:    o_newPc = i_cnd ? i_valC : i_valP;
            IRET:    o_newPc = i_valM;
            default: o_newPc = i_valP;
        endcase
    end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Stage sequencer and PC owner for the sequential Y86-64 core.
// Optional SEQ_PERF_CNT_EN adds saturating cycle/instruction counters.
module seq_stage_ctrl
    import seq_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        imem_error,
    input  logic [63:0] valC,
    input  logic [63:0] valP,
    input  logic        cnd,
    input  logic [63:0] valM,
    input  logic        dmem_error,
    output logic [63:0] pc,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        execute_en,
    output logic        memory_en,
    output logic        writeback_en,
    output logic [1:0]  stat,
    output logic        busy,
    output logic        halted
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    seq_state_e  r_state;
    seq_state_e  w_nextState;
    logic [1:0]  r_stat;
    logic [1:0]  w_nextStat;
    logic [63:0] r_pc;
    logic [3:0]  r_icode;
    logic [63:0] r_valC;
    logic [63:0] r_valP;
    logic        r_cnd;
    logic [63:0] r_valM;
    logic [63:0] w_newPc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_stat  <= STAT_AOK;
        end else begin
            r_state <= w_nextState;
            r_stat  <= w_nextStat;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextStat   = r_stat;
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        execute_en   = 1'b0;
        memory_en    = 1'b0;
        writeback_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_nextState = FETCH;
            end
            FETCH: begin
                fetch_en    = 1'b1;
                w_nextState = DECODE;
            end
            // Fetch results arrive here; faults are ranked ADR, then HLT, then INS.
            DECODE: begin
                decode_en = 1'b1;
                if (imem_error) begin
                    w_nextStat  = STAT_ADR;
                    w_nextState = STOP;
                end else if (icode == IHALT) begin
                    w_nextStat  = STAT_HLT;
                    w_nextState = STOP;
                end else if (isInvalidIcode(icode)) begin
                    w_nextStat  = STAT_INS;
                    w_nextState = STOP;
                end else begin
                    w_nextState = EXECUTE;
                end
            end
            EXECUTE: begin
                execute_en  = 1'b1;
                w_nextState = MEMORY;
            end
            MEMORY: begin
                memory_en   = 1'b1;
                w_nextState = WRITEBACK;
            end
            WRITEBACK: begin
                writeback_en = ~dmem_error;
                if (dmem_error) begin
                    w_nextStat  = STAT_ADR;
                    w_nextState = STOP;
                end else begin
                    w_nextState = PCUPD;
                end
            end
            PCUPD:   w_nextState = FETCH;
            STOP:    w_nextState = STOP;
            default: w_nextState = IDLE;
        endcase
    end

    assign busy   = (r_state != IDLE) && (r_state != STOP);
    assign halted = (r_state == STOP);
    assign stat   = r_stat;
    assign pc     = r_pc;

    seq_pc_select u_pcSelect (
        .i_icode (r_icode),
        .i_cnd   (r_cnd),
        .i_valC  (r_valC),
        .i_valP  (r_valP),
        .i_valM  (r_valM),
        .o_newPc (w_newPc)
    );

    // Each stage result is captured in the cycle after its producer's strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_icode <= 4'd0;
            r_valC  <= 64'd0;
            r_valP  <= 64'd0;
            r_cnd   <= 1'b0;
            r_valM  <= 64'd0;
        end else begin
            case (r_state)
                DECODE: begin
                    r_icode <= icode;
                    r_valC  <= valC;
                    r_valP  <= valP;
                end
                MEMORY:    r_cnd  <= cnd;
                WRITEBACK: r_valM <= valM;
                PCUPD:     r_pc   <= w_newPc;
                default: ;
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_cycleCnt;
    logic [31:0] r_instrCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycleCnt <= 32'd0;
            r_instrCnt <= 32'd0;
        end else begin
            if (busy && (r_cycleCnt != '1)) r_cycleCnt <= r_cycleCnt + 32'd1;
            if ((r_state == PCUPD) && (r_instrCnt != '1)) r_instrCnt <= r_instrCnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycleCnt;
    assign instr_cnt = r_instrCnt;
`endif

endmodule
